apb_master_requester: RTL and testbench

// - APB requester (initiator) matching our APB responder-side controller: accepts one command at a time from a local

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_wait_timer.sv | 41 ++++
 rtl/apb_master_requester.sv | 170 +++++++++++++++++
 tb/tb_apb_master_requester.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus phase enum, response record and timer sizing helper.
package apb_pkg;

    // Bus phase of an APB requester/responder pair.
    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_t;

    // Data width carried by the response record.
    localparam int APB_DATA_WIDTH = 128;

    // Response returned to the command source after each transfer.
    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      error;
        logic                      timeout;
    } apb_rsp_t;

    // Counter width able to hold timeout_cycles-1 with a spare bit for saturation headroom.
    function automatic int timer_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter. Counts cycles while en is high, clears on clr,
// and flags expired once the count has reached limit.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int timeout_cycles = 64,
    localparam int CNT_W = timer_width(timeout_cycles)
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment until all-ones and stick there.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q >= limit);

endmodule

// File: rtl/apb_master_requester.sv
// APB requester: takes one command at a time from a valid/ready port, runs the
// SETUP/ACCESS sequence on the bus and returns a one-cycle response strobe.
// A wait-state timer aborts an ACCESS phase whose PREADY never arrives.
//
// Command handshake: a command transfers on any rising PCLK edge where
// cmd_valid and cmd_ready are both high; cmd_ready never depends on cmd_valid.
// The response side has no backpressure: rsp_valid is a single-cycle strobe and
// the rsp_* fields hold their value until the next strobe.
module apb_master_requester
    import apb_pkg::*;
#(
    parameter int addr_width     = 4,
    parameter int data_width     = 128,
    parameter int timeout_cycles = 64
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [addr_width-1:0] cmd_addr,
    input  logic [data_width-1:0] cmd_wdata,
    // response port
    output logic                  rsp_valid,
    output logic [data_width-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    // APB bus
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [addr_width-1:0] PADDR,
    output logic [data_width-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [data_width-1:0] PRDATA,
    // debug
    output logic [1:0]            dbg_state_o
);

    localparam int TMR_W = timer_width(timeout_cycles);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(timeout_cycles - 1);

    apb_state_t state_q, state_d;

    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [addr_width-1:0] paddr_q, paddr_d;
    logic [data_width-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    apb_rsp_t              rsp_q, rsp_d;

    logic                  tmr_clr;
    logic                  tmr_en;
    logic                  tmr_expired;

    apb_wait_timer #(
        .timeout_cycles(timeout_cycles)
    ) u_wait_timer (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .limit  (TMR_LIMIT),
        .expired(tmr_expired)
    );

    // Next-state, command latch, response capture and cmd_ready decode.
    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_d       = rsp_q;
        cmd_ready   = 1'b0;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;

        case (state_q)
            APB_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    tmr_clr  = 1'b1;
                    state_d  = APB_SETUP;
                end
            end

            APB_SETUP: begin
                state_d = APB_ACCESS;
            end

            APB_ACCESS: begin
                if (PREADY) begin
                    // Completion; a ready in the same cycle as expiry still counts as success.
                    cmd_ready     = 1'b1;
                    rsp_valid_d   = 1'b1;
                    rsp_d.rdata   = pwrite_q ? '0 : APB_DATA_WIDTH'(PRDATA);
                    rsp_d.error   = PSLVERR;
                    rsp_d.timeout = 1'b0;
                    if (cmd_valid) begin
                        pwrite_d = cmd_write;
                        paddr_d  = cmd_addr;
                        pwdata_d = cmd_wdata;
                        tmr_clr  = 1'b1;
                        state_d  = APB_SETUP;
                    end else begin
                        state_d = APB_IDLE;
                    end
                end else if (tmr_expired) begin
                    // Abort: the next command has to start from IDLE.
                    rsp_valid_d   = 1'b1;
                    rsp_d.rdata   = '0;
                    rsp_d.error   = 1'b1;
                    rsp_d.timeout = 1'b1;
                    state_d       = APB_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: begin
                state_d = APB_IDLE;
            end
        endcase

        psel_d    = (state_d != APB_IDLE);
        penable_d = (state_d == APB_ACCESS);
    end

    // State, bus outputs and response register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= APB_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = data_width'(rsp_q.rdata);
    assign rsp_error   = rsp_q.error;
    assign rsp_timeout = rsp_q.timeout;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_master_requester.sv
// Bench for apb_master_requester: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transfer-level model.
module tb_apb_master_requester;

    localparam int AW = 4;
    localparam int DW = 128;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          rsp_timeout;
    logic          PSELx;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY = 1'b1;
    logic          PSLVERR = 1'b0;
    logic [DW-1:0] PRDATA = '0;
    logic [1:0]    dbg_state;

    apb_master_requester #(
        .addr_width(AW),
        .data_width(DW),
        .timeout_cycles(TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .rsp_timeout(rsp_timeout),
        .PSELx      (PSELx),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .PRDATA     (PRDATA),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 PCLK = ~PCLK;

    // ---------------- counters and check helper ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [DW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- APB responder ----------------
    int            wait_plan = 0;     // wait states per transfer; negative selects random
    int            err_plan  = 0;     // PSLVERR at completion: 0, 1, or negative for random
    logic          rd_fixed  = 1'b0;
    logic [DW-1:0] rd_val    = '0;
    int            wait_left = 0;

    // Plays the bus responder: chooses wait states at SETUP, drives junk outside completion.
    always @(posedge PCLK) begin
        #1;
        PSLVERR = 1'($urandom);
        PRDATA  = rand128();
        if (PSELx && !PENABLE) begin
            if (wait_plan < 0) begin
                wait_left = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(4, 6);
            end else begin
                wait_left = wait_plan;
            end
            PREADY = 1'($urandom);
        end else if (PSELx && PENABLE) begin
            if (wait_left > 0) begin
                PREADY = 1'b0;
                wait_left--;
            end else begin
                PREADY = 1'b1;
                if (rd_fixed) PRDATA = rd_val;
                if (err_plan >= 0) PSLVERR = (err_plan != 0);
            end
        end else begin
            PREADY = 1'($urandom);
        end
    end

    // ---------------- transfer-level reference model ----------------
    // A transfer occupies the bus from acceptance until completion/abort: one address
    // cycle, then data cycles until the responder is ready or TO data cycles have
    // gone by without ready. The response appears the cycle after the transfer ends.
    logic          m_ok = 1'b0;
    logic          m_busy, m_in_data;
    int            m_waits;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_rsp_valid;
    logic [DW-1:0] m_rdata;
    logic          m_err, m_to;

    // Compare every cycle, then advance the model from this cycle's inputs.
    always @(negedge PCLK) begin
        logic exp_ready, done, abort, accept;
        exp_ready = !m_busy || (m_in_data && PREADY);
        if (m_ok) begin
            chk("psel",        PSELx,       m_busy);
            chk("penable",     PENABLE,     m_busy && m_in_data);
            chk("cmd_ready",   cmd_ready,   exp_ready);
            chk("pwrite",      PWRITE,      m_write);
            chk("paddr",       PADDR,       m_addr);
            chk("pwdata",      PWDATA,      m_wdata);
            chk("rsp_valid",   rsp_valid,   m_rsp_valid);
            chk("rsp_rdata",   rsp_rdata,   m_rdata);
            chk("rsp_error",   rsp_error,   m_err);
            chk("rsp_timeout", rsp_timeout, m_to);
        end
        if (PRESET) begin
            m_ok = 1'b1; m_busy = 1'b0; m_in_data = 1'b0; m_waits = 0;
            m_write = 1'b0; m_addr = '0; m_wdata = '0;
            m_rsp_valid = 1'b0; m_rdata = '0; m_err = 1'b0; m_to = 1'b0;
        end else if (m_ok) begin
            done   = m_busy && m_in_data && PREADY;
            abort  = m_busy && m_in_data && !PREADY && (m_waits + 1 == TO);
            accept = cmd_valid && exp_ready;
            m_rsp_valid = done || abort;
            if (done) begin
                m_rdata = m_write ? '0 : PRDATA;
                m_err   = PSLVERR;
                m_to    = 1'b0;
            end else if (abort) begin
                m_rdata = '0;
                m_err   = 1'b1;
                m_to    = 1'b1;
            end
            if (m_busy && m_in_data && !done && !abort) m_waits++;
            if (done || abort) m_busy = 1'b0;
            if (m_busy && !m_in_data) begin
                m_in_data = 1'b1;
                m_waits   = 0;
            end
            if (accept) begin
                m_busy    = 1'b1;
                m_in_data = 1'b0;
                m_write   = cmd_write;
                m_addr    = cmd_addr;
                m_wdata   = cmd_wdata;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Offer a command until accepted; returns at the cycle after acceptance.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge PCLK);
            if (cmd_ready) ok = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        if (!ok) bound_expired("send_accept");
    endtask

    // Count cycles (from the one after acceptance) up to and including rsp_valid.
    task automatic wait_rsp(output int lat);
        logic found;
        found = 1'b0;
        lat   = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge PCLK);
            lat++;
            if (rsp_valid) found = 1'b1;
        end
        if (!found) bound_expired("wait_rsp");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int            lat;
        int            idx;
        logic [7:0]    ps, pe, rv;
        logic [DW-1:0] pat;

        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1'b0;

        // reset state
        @(negedge PCLK);
        chk("rst_psel",      PSELx,     1'b0);
        chk("rst_penable",   PENABLE,   1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_paddr",     PADDR,     '0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_state",     dbg_state, 2'd0);
        tick();

        // write, zero wait states
        wait_plan = 0; err_plan = 0;
        pat = {16{8'h0F}};
        send(1'b1, 4'h3, pat);
        @(negedge PCLK);
        chk("t1_setup_psel",    PSELx,   1'b1);
        chk("t1_setup_penable", PENABLE, 1'b0);
        chk("t1_setup_pwdata",  PWDATA,  pat);
        tick();
        @(negedge PCLK);
        chk("t1_access_psel",    PSELx,   1'b1);
        chk("t1_access_penable", PENABLE, 1'b1);
        tick();
        @(negedge PCLK);
        chk("t1_rsp_valid", rsp_valid, 1'b1);
        chk("t1_rsp_error", rsp_error, 1'b0);
        chk("t1_rsp_rdata", rsp_rdata, '0);
        chk("t1_psel_idle", PSELx,     1'b0);
        tick();

        // read with 3 wait states
        wait_plan = 3; rd_fixed = 1'b1; rd_val = 128'hDEAD_BEEF;
        send(1'b0, 4'h5, rand128());
        wait_rsp(lat);
        chk("t2_latency",   lat,       6);
        chk("t2_rsp_rdata", rsp_rdata, 128'hDEAD_BEEF);
        chk("t2_rsp_error", rsp_error, 1'b0);
        tick();

        // slave error on read of the top address
        wait_plan = 0; err_plan = 1;
        send(1'b0, 4'hF, '0);
        wait_rsp(lat);
        chk("t3_latency",     lat,         3);
        chk("t3_rsp_error",   rsp_error,   1'b1);
        chk("t3_rsp_timeout", rsp_timeout, 1'b0);
        err_plan = 0;
        tick();

        // timeout: ready never arrives
        wait_plan = 1000;
        send(1'b1, 4'h8, rand128());
        wait_rsp(lat);
        chk("t4_latency",     lat,         6);
        chk("t4_rsp_error",   rsp_error,   1'b1);
        chk("t4_rsp_timeout", rsp_timeout, 1'b1);
        chk("t4_rsp_rdata",   rsp_rdata,   '0);
        chk("t4_psel_after",  PSELx,       1'b0);
        tick();

        // ready on the last allowed data cycle completes normally
        wait_plan = 3; rd_val = 128'h1234;
        send(1'b0, 4'h2, '0);
        wait_rsp(lat);
        chk("t4v_latency",     lat,         6);
        chk("t4v_rsp_timeout", rsp_timeout, 1'b0);
        chk("t4v_rsp_rdata",   rsp_rdata,   128'h1234);
        rd_fixed = 1'b0;
        tick();

        // back-to-back: three commands with valid held
        wait_plan = 0;
        idx = 0;
        cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = 4'($urandom); cmd_wdata = rand128();
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            ps[i] = PSELx;
            pe[i] = PENABLE;
            rv[i] = rsp_valid;
            if (cmd_valid && cmd_ready) idx++;
            tick();
            if (idx >= 3) begin
                cmd_valid = 1'b0;
            end else begin
                cmd_write = 1'($urandom); cmd_addr = 4'($urandom); cmd_wdata = rand128();
            end
        end
        chk("t5_accepts", idx, 3);
        chk("t5_psel",    ps,  8'b0111_1110);
        chk("t5_penable", pe,  8'b0101_0100);
        chk("t5_rsp",     rv,  8'b1010_1000);

        // reset in the middle of a stalled ACCESS
        wait_plan = 1000;
        send(1'b0, 4'h9, rand128());
        tick();
        tick();
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("t6_psel",      PSELx,     1'b0);
        chk("t6_penable",   PENABLE,   1'b0);
        chk("t6_rsp_valid", rsp_valid, 1'b0);
        chk("t6_paddr",     PADDR,     '0);
        chk("t6_rsp_error", rsp_error, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge PCLK);
            chk("t6_no_rsp", rsp_valid, 1'b0);
        end
        tick();

        // randomized traffic
        wait_plan = -1; err_plan = -1;
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(1'($urandom), 4'($urandom), rand128());
        end
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
